hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core. It keeps a shadow copy of the register-usage information for the EX, MEM and WB stages.
- It drives the execute stage's forwardA/forwardB selects (00 = regfile, 01 = MEM/WB writeback, 10 = EX/MEM ALU result).
- It also detects load-use hazards, sequences stalls, bubbles and branch flushes, and keeps saturating stall/flush counters.

---
 rtl/hazard_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller interface: ID-stage register usage and pipeline events in,
// forwarding selects, stall/bubble/flush controls and performance counters out.
interface hazard_if #(
  parameter int unsigned REG_BITS  = 3,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 id_valid;
  logic [REG_BITS-1:0]  id_rs;
  logic [REG_BITS-1:0]  id_rt;
  logic                 id_useRs;
  logic                 id_useRt;
  logic                 id_regWrite;
  logic [REG_BITS-1:0]  id_writeReg;
  logic                 id_memRead;
  logic                 ex_branchTaken;
  logic                 mem_stall;
  logic [1:0]           forwardA;
  logic [1:0]           forwardB;
  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 idex_bubble;
  logic                 ifid_flush;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_useRs, id_useRt, id_regWrite, id_writeReg,
           id_memRead, ex_branchTaken, mem_stall,
    input  forwardA, forwardB, pc_stall, ifid_stall, idex_bubble, ifid_flush,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_useRs, id_useRt, id_regWrite, id_writeReg,
           id_memRead, ex_branchTaken, mem_stall,
    output forwardA, forwardB, pc_stall, ifid_stall, idex_bubble, ifid_flush,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB register usage, drives EX forwarding
// selects, detects load-use hazards, sequences stall/bubble/flush, counts events.
module hazard_ctrl #(
  parameter int unsigned REG_BITS  = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hz
);
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [REG_BITS-1:0] dest;
  } stage_t;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                load;
    logic                use_rs;
    logic                use_rt;
    logic [REG_BITS-1:0] dest;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
  } ex_t;

  ex_t                  ex_q, ex_d;
  stage_t               mem_q, mem_d, wb_q, wb_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 rs_hit_c, rt_hit_c, load_use_c;
  logic                 pc_stall_c, ifid_stall_c, idex_bubble_c, ifid_flush_c;

  // MEM result beats WB result; an empty or non-reading EX slot never forwards
  function automatic logic [1:0] fwd_sel(input logic en, input logic [REG_BITS-1:0] src,
                                         input stage_t mem, input stage_t wb);
    if (en && mem.valid && mem.we && (mem.dest == src)) return 2'b10;
    if (en && wb.valid && wb.we && (wb.dest == src))    return 2'b01;
    return 2'b00;
  endfunction

  assign rs_hit_c   = hz.id_useRs & (hz.id_rs == ex_q.dest);
  assign rt_hit_c   = hz.id_useRt & (hz.id_rt == ex_q.dest);
  assign load_use_c = hz.id_valid & ex_q.valid & ex_q.load & ex_q.we & (rs_hit_c | rt_hit_c);

  // Control priority: memory freeze, then branch flush, then load-use stall
  always_comb begin
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ifid_flush_c  = 1'b0;
    if (hz.mem_stall) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
    end else if (hz.ex_branchTaken) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (load_use_c) begin
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end
  end

  // Shadow advance and saturating counters; everything holds while frozen
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.mem_stall) begin
      wb_d  = mem_q;
      mem_d = '{valid: ex_q.valid, we: ex_q.we, dest: ex_q.dest};
      ex_d  = '{valid:  hz.id_valid & ~idex_bubble_c,
                we:     hz.id_regWrite,
                load:   hz.id_memRead,
                use_rs: hz.id_useRs,
                use_rt: hz.id_useRt,
                dest:   hz.id_writeReg,
                rs:     hz.id_rs,
                rt:     hz.id_rt};
      if (ifid_flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      if (idex_bubble_c && !ifid_flush_c && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.forwardA    = fwd_sel(ex_q.valid & ex_q.use_rs, ex_q.rs, mem_q, wb_q);
  assign hz.forwardB    = fwd_sel(ex_q.valid & ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  assign hz.pc_stall    = pc_stall_c;
  assign hz.ifid_stall  = ifid_stall_c;
  assign hz.idex_bubble = idex_bubble_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: scoreboarded forwarding results plus inline
// control/counter checks; a narrow-counter second instance exercises saturation.
module tb_hazard_ctrl;
  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       we;
    logic [2:0] wd;
    logic       ld;
  } instr_t;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  exp_t sb_q[$];

  hazard_if #(.REG_BITS(3), .CNT_WIDTH(16)) hz ();
  hazard_if #(.REG_BITS(3), .CNT_WIDTH(4))  hz_s ();

  hazard_ctrl #(.REG_BITS(3), .CNT_WIDTH(16)) u_dut (.clk(clk), .rst(rst), .hz(hz));
  hazard_ctrl #(.REG_BITS(3), .CNT_WIDTH(4))  u_sat (.clk(clk), .rst(rst), .hz(hz_s));

  assign hz_s.id_valid       = hz.id_valid;
  assign hz_s.id_rs          = hz.id_rs;
  assign hz_s.id_rt          = hz.id_rt;
  assign hz_s.id_useRs       = hz.id_useRs;
  assign hz_s.id_useRt       = hz.id_useRt;
  assign hz_s.id_regWrite    = hz.id_regWrite;
  assign hz_s.id_writeReg    = hz.id_writeReg;
  assign hz_s.id_memRead     = hz.id_memRead;
  assign hz_s.ex_branchTaken = hz.ex_branchTaken;
  assign hz_s.mem_stall      = hz.mem_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk(input int v, input int rs, input int rt, input int urs,
                                input int urt, input int we, input int wd, input int ld);
    return '{v: 1'(v), rs: 3'(rs), rt: 3'(rt), urs: 1'(urs), urt: 1'(urt),
             we: 1'(we), wd: 3'(wd), ld: 1'(ld)};
  endfunction

  task automatic drive(input instr_t i);
    hz.id_valid    = i.v;
    hz.id_rs       = i.rs;
    hz.id_rt       = i.rt;
    hz.id_useRs    = i.urs;
    hz.id_useRt    = i.urt;
    hz.id_regWrite = i.we;
    hz.id_writeReg = i.wd;
    hz.id_memRead  = i.ld;
  endtask

  task automatic push(input string n, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.name = n; e.fa = fa; e.fb = fb;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three empty slots drain EX/MEM/WB; each empty EX must give 00/00
  task automatic drain(input string tag);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      push(tag, 2'b00, 2'b00);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
        errors++;
        $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    hz.ex_branchTaken = 1'b1;
    hz.mem_stall = 1'b0;
    drive(mk(1, 1, 2, 1, 1, 1, 3, 0));
    tick();
    tick();
    rst = 1'b0;
    hz.ex_branchTaken = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    push("reset_fwd", 2'b00, 2'b00);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
      errors++;
      $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
    end
    checks++;
    if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000",
               {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush});
    end
    checks++;
    if (hz.stall_count !== 16'd0 || hz.flush_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", hz.stall_count, hz.flush_count);
    end
    tick();
  endtask

  task automatic test_distance();
    instr_t     prog [5];
    logic [1:0] ea [5];
    logic [1:0] eb [5];
    exp_t       e;
    prog[0] = mk(1, 1, 2, 1, 1, 1, 3, 0); ea[0] = 2'b00; eb[0] = 2'b00;
    prog[1] = mk(1, 3, 4, 1, 1, 1, 5, 0); ea[1] = 2'b10; eb[1] = 2'b00;
    prog[2] = mk(1, 1, 2, 1, 1, 1, 6, 0); ea[2] = 2'b00; eb[2] = 2'b00;
    prog[3] = mk(1, 5, 7, 1, 1, 1, 7, 0); ea[3] = 2'b01; eb[3] = 2'b00;
    prog[4] = mk(1, 1, 6, 1, 1, 1, 1, 0); ea[4] = 2'b00; eb[4] = 2'b01;
    for (int i = 0; i < 5; i++) begin
      drive(prog[i]);
      push($sformatf("dist%0d", i), ea[i], eb[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
        errors++;
        $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_double();
    instr_t     prog [3];
    logic [1:0] ef [3];
    exp_t       e;
    prog[0] = mk(1, 0, 0, 0, 0, 1, 2, 0); ef[0] = 2'b00;
    prog[1] = mk(1, 0, 0, 0, 0, 1, 2, 0); ef[1] = 2'b00;
    prog[2] = mk(1, 2, 2, 1, 1, 0, 0, 0); ef[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      drive(prog[i]);
      push($sformatf("double%0d", i), ef[i], ef[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
        errors++;
        $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_loaduse();
    exp_t       e;
    logic [3:0] want [3];
    logic [1:0] eb [3];
    want[0] = 4'b0000; eb[0] = 2'b00;
    want[1] = 4'b1110; eb[1] = 2'b00;
    want[2] = 4'b0000; eb[2] = 2'b01;
    drain("lu_drain");
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(mk(1, 2, 0, 1, 0, 1, 1, 1));
      else        drive(mk(1, 3, 1, 1, 1, 1, 4, 0));
      #1;
      checks++;
      if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== want[i]) begin
        errors++;
        $display("FAIL lu_ctrl%0d got %b want %b", i,
                 {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, want[i]);
      end
      push($sformatf("lu_fwd%0d", i), 2'b00, eb[i]);
      tick();
      if (want[i][1]) exp_stall++;
      e = sb_q.pop_front();
      checks++;
      if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
        errors++;
        $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
      end
      checks++;
      if (hz.stall_count !== 16'(exp_stall)) begin
        errors++;
        $display("FAIL lu_cnt%0d got %0d want %0d", i, hz.stall_count, exp_stall);
      end
    end
  endtask

  task automatic test_flush_over_stall();
    exp_t e;
    drain("fl_drain");
    drive(mk(1, 0, 0, 0, 0, 1, 2, 1));
    tick();
    drive(mk(1, 2, 0, 1, 0, 1, 3, 0));
    hz.ex_branchTaken = 1'b1;
    #1;
    checks++;
    if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== 4'b0011) begin
      errors++;
      $display("FAIL flush_ctrl got %b want 0011",
               {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush});
    end
    push("flush_fwd", 2'b00, 2'b00);
    tick();
    hz.ex_branchTaken = 1'b0;
    exp_flush++;
    e = sb_q.pop_front();
    checks++;
    if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
      errors++;
      $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
    end
    checks++;
    if (hz.flush_count !== 16'(exp_flush) || hz.stall_count !== 16'(exp_stall)) begin
      errors++;
      $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", hz.flush_count, hz.stall_count,
               exp_flush, exp_stall);
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    drain("frz_drain");
    drive(mk(1, 0, 0, 0, 0, 1, 7, 0));
    tick();
    drive(mk(1, 7, 0, 1, 0, 1, 5, 1));
    push("frz_ld", 2'b10, 2'b00);
    tick();
    e = sb_q.pop_front();
    checks++;
    if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
      errors++;
      $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
    end
    drive(mk(1, 5, 0, 1, 0, 1, 6, 0));
    hz.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== 4'b1100) begin
        errors++;
        $display("FAIL frz_ctrl%0d got %b want 1100", i,
                 {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush});
      end
      push($sformatf("frz_hold%0d", i), 2'b10, 2'b00);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
        errors++;
        $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
      end
      checks++;
      if (hz.stall_count !== 16'(exp_stall) || hz.flush_count !== 16'(exp_flush)) begin
        errors++;
        $display("FAIL frz_cnt%0d got %0d/%0d want %0d/%0d", i, hz.stall_count,
                 hz.flush_count, exp_stall, exp_flush);
      end
    end
    hz.mem_stall = 1'b0;
    #1;
    checks++;
    if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== 4'b1110) begin
      errors++;
      $display("FAIL frz_release got %b want 1110",
               {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush});
    end
    push("frz_bubble", 2'b00, 2'b00);
    tick();
    exp_stall++;
    e = sb_q.pop_front();
    checks++;
    if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb} || hz.stall_count !== 16'(exp_stall)) begin
      errors++;
      $display("FAIL %s got %b/%b cnt %0d want %b/%b cnt %0d", e.name, hz.forwardA,
               hz.forwardB, hz.stall_count, e.fa, e.fb, exp_stall);
    end
    push("frz_fwd", 2'b01, 2'b00);
    tick();
    e = sb_q.pop_front();
    checks++;
    if ({hz.forwardA, hz.forwardB} !== {e.fa, e.fb}) begin
      errors++;
      $display("FAIL %s fwd got %b/%b want %b/%b", e.name, hz.forwardA, hz.forwardB, e.fa, e.fb);
    end
  endtask

  // A load that reads its own destination stalls every other cycle while held in ID
  task automatic test_saturation();
    logic in_ex = 1'b0;
    drain("sat_drain");
    drive(mk(1, 1, 0, 1, 0, 1, 1, 1));
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++;
      if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !==
          (in_ex ? 4'b1110 : 4'b0000)) begin
        errors++;
        $display("FAIL sat_ctrl%0d got %b want %b", i,
                 {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush},
                 (in_ex ? 4'b1110 : 4'b0000));
      end
      tick();
      if (in_ex) exp_stall++;
      in_ex = ~in_ex;
    end
    checks++;
    if (hz.stall_count !== 16'(exp_stall)) begin
      errors++;
      $display("FAIL sat_main got %0d want %0d", hz.stall_count, exp_stall);
    end
    checks++;
    if (hz_s.stall_count !== 4'hF || hz_s.flush_count !== 4'(exp_flush)) begin
      errors++;
      $display("FAIL sat_narrow got %h/%h want f/%h", hz_s.stall_count, hz_s.flush_count,
               4'(exp_flush));
    end
  endtask

  task automatic test_reset_mid_stall();
    drain("rm_drain");
    drive(mk(1, 0, 0, 0, 0, 1, 1, 1));
    tick();
    drive(mk(1, 1, 0, 1, 0, 1, 2, 0));
    #1;
    checks++;
    if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== 4'b1110) begin
      errors++;
      $display("FAIL rm_pre got %b want 1110",
               {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush} !== 4'b0000 ||
        hz.stall_count !== 16'd0 || hz.flush_count !== 16'd0) begin
      errors++;
      $display("FAIL rm_post got %b cnt %0d/%0d want 0000 cnt 0/0",
               {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush},
               hz.stall_count, hz.flush_count);
    end
  endtask

  initial begin
    test_reset();
    test_distance();
    test_double();
    test_loaduse();
    test_flush_over_stall();
    test_freeze();
    test_saturation();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
